compressor_stream_arbiter: RTL and testbench

Packet-granular round-robin arbiter that shares one `Compressor` between `NUM_PORTS` AXI-stream sources. It sits directly upstream of the compressor's `data_in`/`tvalid_in`/`tlast_in`/`tkeep_in`/`tready_out` interface. Once a port is granted, it holds the grant until its `tlast` beat is accepted, so packets never interleave. Every output beat is tagged with the index of its source port.

---
 rtl/compressor_pkg.sv | 13 +
 rtl/compressor_stream_arbiter_rr_pick.sv | 34 +++
 rtl/compressor_stream_arbiter.sv | 120 ++++++++++++
 tb/tb_compressor_stream_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/compressor_pkg.sv
// rtl/compressor_pkg.sv - shared widths and arbiter state encoding for the compressor datapath
package compressor_pkg;

    // Beat geometry shared with the Compressor core.
    localparam int DEFAULT_DATA_WIDTH = 256;
    localparam int DEFAULT_KEEP_WIDTH = DEFAULT_DATA_WIDTH / 8;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_t;

endpackage

// File: rtl/compressor_stream_arbiter_rr_pick.sv
// rtl/compressor_stream_arbiter_rr_pick.sv - combinational round-robin picker
//
// Ports:
//   req  [NUM_PORTS] : request vector
//   last [ID_WIDTH]  : index granted most recently
//   pick [ID_WIDTH]  : first requesting index at or after last+1, modulo NUM_PORTS
//   any              : at least one request present
module rr_pick #(
    parameter int NUM_PORTS = 4,
    parameter int ID_WIDTH  = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [ID_WIDTH-1:0]  last,
    output logic [ID_WIDTH-1:0]  pick,
    output logic                 any
);

    // Walk the ring from farthest to nearest so the nearest requester wins
    // by being assigned last.
    always_comb begin
        int idx;
        idx  = 0;
        pick = '0;
        any  = 1'b0;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            idx = (int'(last) + i) % NUM_PORTS;
            if (req[idx]) begin
                pick = ID_WIDTH'(idx);
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/compressor_stream_arbiter.sv
// rtl/compressor_stream_arbiter.sv - packet-granular round-robin arbiter in front of the Compressor
//
// Ports:
//   clk, reset_n                  : clock, async active-low reset
//   port_mask [NUM_PORTS]         : per-port grant eligibility, sampled in IDLE
//   s_tdata/s_tkeep/s_tvalid/
//   s_tlast/s_tready              : NUM_PORTS packed input streams
//   m_tdata/m_tkeep/m_tvalid/
//   m_tlast/m_tid/m_tready        : registered output stream to the Compressor
//   busy                          : a packet is currently granted
module compressor_stream_arbiter
    import compressor_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = (NUM_PORTS <= 2) ? 1 : $clog2(NUM_PORTS)
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_PORTS-1:0]             port_mask,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_tdata,
    input  logic [NUM_PORTS*KEEP_WIDTH-1:0]  s_tkeep,
    input  logic [NUM_PORTS-1:0]             s_tvalid,
    input  logic [NUM_PORTS-1:0]             s_tlast,
    output logic [NUM_PORTS-1:0]             s_tready,
    output logic [DATA_WIDTH-1:0]            m_tdata,
    output logic [KEEP_WIDTH-1:0]            m_tkeep,
    output logic                             m_tvalid,
    output logic                             m_tlast,
    output logic [ID_WIDTH-1:0]              m_tid,
    input  logic                             m_tready,
    output logic                             busy
);

    arb_state_t            state, next_state;
    logic [ID_WIDTH-1:0]   grant, last_grant, pick;
    logic                  any_req;
    logic                  out_ready;
    logic                  accept;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [KEEP_WIDTH-1:0] sel_keep;
    logic                  sel_valid, sel_last;

    rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .ID_WIDTH  (ID_WIDTH)
    ) u_rr_pick (
        .req  (s_tvalid & port_mask),
        .last (last_grant),
        .pick (pick),
        .any  (any_req)
    );

    // Output register can take a beat when empty or draining this cycle.
    assign out_ready = !m_tvalid || m_tready;
    assign accept    = (state == ARB_BUSY) && sel_valid && out_ready;
    assign busy      = (state == ARB_BUSY);

    // Granted-port mux and one-hot ready decode; ready never looks at s_tvalid.
    always_comb begin
        sel_data  = '0;
        sel_keep  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        s_tready  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant == ID_WIDTH'(p)) begin
                sel_data    = s_tdata[p*DATA_WIDTH +: DATA_WIDTH];
                sel_keep    = s_tkeep[p*KEEP_WIDTH +: KEEP_WIDTH];
                sel_valid   = s_tvalid[p];
                sel_last    = s_tlast[p];
                s_tready[p] = (state == ARB_BUSY) && out_ready;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ARB_IDLE: if (any_req)            next_state = ARB_BUSY;
            ARB_BUSY: if (accept && sel_last) next_state = ARB_IDLE;
            default:                          next_state = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ARB_IDLE;
            grant      <= '0;
            // Start the pointer on the last port so port 0 is searched first.
            last_grant <= ID_WIDTH'(NUM_PORTS - 1);
        end else begin
            state <= next_state;
            if (state == ARB_IDLE && any_req) begin
                grant      <= pick;
                last_grant <= pick;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_tdata  <= '0;
            m_tkeep  <= '0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            m_tid    <= '0;
        end else if (accept) begin
            m_tdata  <= sel_data;
            m_tkeep  <= sel_keep;
            m_tvalid <= 1'b1;
            m_tlast  <= sel_last;
            m_tid    <= grant;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_compressor_stream_arbiter.sv
// tb/tb_compressor_stream_arbiter.sv - scoreboard bench for compressor_stream_arbiter
module tb_compressor_stream_arbiter;

    localparam int NP = 4;
    localparam int DW = 256;
    localparam int KW = 32;
    localparam int IW = 2;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    typedef struct {
        logic [IW-1:0] tid;
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic [NP-1:0]     port_mask = '1;
    logic [NP*DW-1:0]  s_tdata = '0;
    logic [NP*KW-1:0]  s_tkeep = '0;
    logic [NP-1:0]     s_tvalid = '0;
    logic [NP-1:0]     s_tlast = '0;
    logic [NP-1:0]     s_tready;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tkeep;
    logic              m_tvalid;
    logic              m_tlast;
    logic [IW-1:0]     m_tid;
    logic              m_tready = 1'b1;
    logic              busy;

    compressor_stream_arbiter #(
        .NUM_PORTS  (NP),
        .DATA_WIDTH (DW),
        .KEEP_WIDTH (KW),
        .ID_WIDTH   (IW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .port_mask (port_mask),
        .s_tdata   (s_tdata),
        .s_tkeep   (s_tkeep),
        .s_tvalid  (s_tvalid),
        .s_tlast   (s_tlast),
        .s_tready  (s_tready),
        .m_tdata   (m_tdata),
        .m_tkeep   (m_tkeep),
        .m_tvalid  (m_tvalid),
        .m_tlast   (m_tlast),
        .m_tid     (m_tid),
        .m_tready  (m_tready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          out_cnt = 0;
    beat_t       src_q[NP][$];
    exp_t        sb[$];
    int          order[$];
    int          out_cyc[$];
    logic [NP-1:0] acc_seen = '0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor: handshakes complete on the coming rising edge, so sample at negedge.
    always @(negedge clk) begin
        if (!reset_n) begin
            sb.delete();
            order.delete();
            out_cyc.delete();
            out_cnt = 0;
            acc_seen = '0;
        end else begin
            check("s_tready_onehot", ($countones(s_tready) <= 1), 1);
            if (m_tvalid && m_tready) begin
                out_cnt++;
                out_cyc.push_back(cyc);
                if (m_tlast) order.push_back(int'(m_tid));
                if (sb.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("m_tid", m_tid, e.tid);
                    check("m_tdata", m_tdata, e.data);
                    check("m_tkeep", m_tkeep, e.keep);
                    check("m_tlast", m_tlast, e.last);
                end
            end
            for (int p = 0; p < NP; p++) begin
                acc_seen[p] = s_tvalid[p] && s_tready[p];
                if (acc_seen[p]) begin
                    exp_t e;
                    e.tid  = IW'(p);
                    e.data = src_q[p][0].data;
                    e.keep = src_q[p][0].keep;
                    e.last = src_q[p][0].last;
                    sb.push_back(e);
                end
            end
        end
    end

    task automatic add_beat(input int p, input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
        beat_t b;
        b.data = d;
        b.keep = k;
        b.last = l;
        src_q[p].push_back(b);
    endtask

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            s_tvalid[p] = (src_q[p].size() > 0);
            if (src_q[p].size() > 0) begin
                s_tdata[p*DW +: DW] = src_q[p][0].data;
                s_tkeep[p*KW +: KW] = src_q[p][0].keep;
                s_tlast[p]          = src_q[p][0].last;
            end else begin
                s_tdata[p*DW +: DW] = '0;
                s_tkeep[p*KW +: KW] = '0;
                s_tlast[p]          = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        for (int p = 0; p < NP; p++)
            if (acc_seen[p]) void'(src_q[p].pop_front());
        drive();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tlast", m_tlast, 0);
        check("rst_busy", busy, 0);
        check("rst_s_tready", s_tready, 0);
        check("rst_m_tid", m_tid, 0);
        check("rst_m_tdata", m_tdata, 0);
        check("rst_m_tkeep", m_tkeep, 0);
        for (int p = 0; p < NP; p++) src_q[p].delete();
        port_mask = '1;
        m_tready  = 1'b1;
        drive();
        @(negedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (src_q[0].size() == 0 && src_q[1].size() == 0 && src_q[2].size() == 0 &&
                src_q[3].size() == 0 && sb.size() == 0 && !m_tvalid) begin
                done = 1'b1;
                break;
            end
            step();
        end
        check("drain_timeout", done, 1);
    endtask

    task automatic check_order(input string tag, input int exp_ids[$]);
        check({tag, "_count"}, (order.size() >= exp_ids.size()), 1);
        for (int i = 0; i < exp_ids.size() && i < order.size(); i++)
            check(tag, order[i], exp_ids[i]);
    endtask

    initial begin
        int c0;
        logic [DW-1:0] held_data;
        logic [IW-1:0] held_id;

        do_reset();

        // Port 2, two-beat packet with partial keep on the tail.
        add_beat(2, 256'hA1, 32'hFFFF_FFFF, 1'b0);
        add_beat(2, 256'hA2, 32'h0000_FFFF, 1'b1);
        step();
        c0 = cyc;
        for (int i = 0; i < 10 && !m_tvalid; i++) step();
        check("t1_first_valid_latency", cyc - c0, 2);
        for (int i = 0; i < 10 && src_q[2].size() > 0; i++) step();
        check("t1_busy_after_tlast", busy, 0);
        drain();
        check("t1_out_count", out_cnt, 2);
        check_order("t1_order", '{2});

        // All ports streaming single-beat packets.
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < NP; p++)
                add_beat(p, DW'(16 * r + p + 256'h100), 32'hFFFF_FFFF, 1'b1);
        drive();
        drain();
        check_order("t2_order", '{0, 1, 2, 3, 0, 1, 2, 3});
        for (int i = 1; i < out_cyc.size(); i++)
            check("t2_gap", out_cyc[i] - out_cyc[i-1], 2);

        // Port 1 holds its grant while ports 0 and 3 wait.
        do_reset();
        for (int i = 0; i < 3; i++) add_beat(1, DW'(256'h200 + i), 32'hFFFF_FFFF, (i == 2));
        step();
        step();
        add_beat(0, 256'h300, 32'h0000_00FF, 1'b1);
        add_beat(3, 256'h330, 32'h0000_0000, 1'b1);
        for (int i = 0; i < 20 && src_q[1].size() > 0; i++) begin
            step();
            check("t3_p0_blocked", s_tready[0], 0);
            check("t3_p3_blocked", s_tready[3], 0);
        end
        drain();
        check_order("t3_order", '{1, 3, 0});

        // Downstream stall mid-packet.
        do_reset();
        for (int i = 1; i <= 4; i++) add_beat(0, DW'(i), 32'hFFFF_FFFF, (i == 4));
        drive();
        for (int i = 0; i < 10 && !m_tvalid; i++) step();
        step();
        m_tready  = 1'b0;
        #1;
        held_data = m_tdata;
        held_id   = m_tid;
        check("t4_stall_data_is_beat2", held_data, 2);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_stall_data", m_tdata, held_data);
            check("t4_stall_tid", m_tid, held_id);
            check("t4_stall_tvalid", m_tvalid, 1);
            check("t4_stall_s_tready", s_tready, 0);
        end
        m_tready = 1'b1;
        drain();
        check("t4_out_count", out_cnt, 4);

        // Mask leaves only ports 1 and 3 eligible.
        do_reset();
        port_mask = 4'b1010;
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < NP; p++)
                add_beat(p, DW'(256'h400 + 16 * r + p), 32'hFFFF_FFFF, 1'b1);
        drive();
        for (int i = 0; i < 40; i++) step();
        check_order("t5_order", '{1, 3, 1, 3});
        check("t5_total_packets", order.size(), 4);

        // Reset in the middle of a four-beat packet.
        do_reset();
        for (int i = 1; i <= 4; i++) add_beat(2, DW'(256'h500 + i), 32'hFFFF_FFFF, (i == 4));
        drive();
        for (int i = 0; i < 10 && !m_tvalid; i++) step();
        step();
        check("t6_mid_packet_busy", busy, 1);
        do_reset();
        add_beat(0, 256'h600, 32'hFFFF_FFFF, 1'b1);
        add_beat(2, 256'h620, 32'hFFFF_FFFF, 1'b1);
        drive();
        drain();
        check_order("t6_order_after_reset", '{0, 2});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
